// File: rtl/qpmm_issue_sched.sv
// qpmm_issue_sched: in-order issue scheduler driving the QPMM operand-read and result-write RAM ports.
// Optional feature: define QPMM_HAZARD_CHECK_EN to build the read-after-write stall comparators.
module qpmm_issue_sched #(
    parameter int AW      = 8,
    parameter int RD_LAT  = 3,
    parameter int MUL_LAT = 36
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_a,
    input  logic [AW-1:0] cmd_b,
    input  logic [AW-1:0] cmd_z,
    input  logic          cmd_last,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          busy,
    output logic          done
);
    localparam int D = RD_LAT + MUL_LAT;

    logic [D-1:0]  valid_r;
    logic [D-1:0]  last_r;
    logic [AW-1:0] z_r [D];
    logic          rd_en_r;
    logic [AW-1:0] rd_addr_a_r;
    logic [AW-1:0] rd_addr_b_r;
    logic          wr_en_r;
    logic [AW-1:0] wr_addr_r;
    logic          done_r;
    logic          hazard_s;
    logic          fire_s;

    assign fire_s    = cmd_valid & cmd_ready;
    assign cmd_ready = rstn & ~hazard_s;

    // In-flight tracking: one stage per cycle between read issue and write-back
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_r <= {D{1'b0}};
            last_r  <= {D{1'b0}};
            for (int i = 0; i < D; i++) begin
                z_r[i] <= {AW{1'b0}};
            end
        end else begin
            valid_r <= {valid_r[D-2:0], fire_s};
            last_r  <= {last_r[D-2:0], fire_s & cmd_last};
            z_r[0]  <= cmd_z;
            for (int i = 1; i < D; i++) begin
                z_r[i] <= z_r[i-1];
            end
        end
    end

    // Read issue: strobe follows the handshake; addresses hold between commands
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_en_r     <= 1'b0;
            rd_addr_a_r <= {AW{1'b0}};
            rd_addr_b_r <= {AW{1'b0}};
        end else begin
            rd_en_r <= fire_s;
            if (fire_s) begin
                rd_addr_a_r <= cmd_a;
                rd_addr_b_r <= cmd_b;
            end
        end
    end

    // Write-back stage: the oldest entry leaves the shift register here
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= {AW{1'b0}};
            done_r    <= 1'b0;
        end else begin
            wr_en_r <= valid_r[D-1];
            done_r  <= valid_r[D-1] & last_r[D-1];
            if (valid_r[D-1]) begin
                wr_addr_r <= z_r[D-1];
            end
        end
    end

`ifdef QPMM_HAZARD_CHECK_EN
    // RAW check against every pending destination, the write-back cycle included
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < D; i++) begin
            hazard_s = hazard_s | (valid_r[i] & ((z_r[i] == cmd_a) | (z_r[i] == cmd_b)));
        end
        hazard_s = hazard_s | (wr_en_r & ((wr_addr_r == cmd_a) | (wr_addr_r == cmd_b)));
    end
`else
    assign hazard_s = 1'b0;
`endif

    assign rd_en     = rd_en_r;
    assign rd_addr_a = rd_addr_a_r;
    assign rd_addr_b = rd_addr_b_r;
    assign wr_en     = wr_en_r;
    assign wr_addr   = wr_addr_r;
    assign done      = done_r;
    assign busy      = (|valid_r) | wr_en_r;

endmodule

// File: tb/tb_qpmm_issue_sched.sv
// Bench for qpmm_issue_sched: expected outputs come from a history of accepted commands
// and their handshake cycles, evaluated with the issue/write-back/hazard timing rules.
module tb_qpmm_issue_sched;
    localparam int AW      = 8;
    localparam int RD_LAT  = 3;
    localparam int MUL_LAT = 36;
    localparam int D       = RD_LAT + MUL_LAT;
    localparam int VW      = 3 * AW + 5;
`ifdef QPMM_HAZARD_CHECK_EN
    localparam bit HAZ = 1'b1;
`else
    localparam bit HAZ = 1'b0;
`endif

    typedef struct {
        int            hs;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [AW-1:0] z;
        logic          last;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_a;
    logic [AW-1:0] cmd_b;
    logic [AW-1:0] cmd_z;
    logic          cmd_last;
    logic          rd_en;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          busy;
    logic          done;

    cmd_t hist[$];
    cmd_t pend[$];
    int   cyc     = 0;
    int   n_cmp   = 0;
    int   n_err   = 0;
    bit   drop_en = 1'b0;

    qpmm_issue_sched #(.AW(AW), .RD_LAT(RD_LAT), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_z(cmd_z), .cmd_last(cmd_last),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic cmd_t mk(int a, int b, int z, bit last);
        cmd_t c;
        c.hs = 0; c.a = AW'(a); c.b = AW'(b); c.z = AW'(z); c.last = last;
        return c;
    endfunction

    function automatic logic [VW-1:0] obs();
        return {cmd_ready, rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr, busy, done};
    endfunction

    // Reference: command with handshake h reads in h+1, writes in h+1+D, occupies h+1..h+1+D
    function automatic logic [VW-1:0] model_out();
        logic          rdy, rde, wre, bsy, dn;
        logic [AW-1:0] ra, rb, wa;
        rdy = rstn; rde = 1'b0; wre = 1'b0; bsy = 1'b0; dn = 1'b0;
        ra = '0; rb = '0; wa = '0;
        foreach (hist[i]) begin
            if (hist[i].hs == cyc - 1) rde = 1'b1;
            if (hist[i].hs <= cyc - 1) begin ra = hist[i].a; rb = hist[i].b; end
            if (hist[i].hs + 1 + D == cyc) begin wre = 1'b1; dn = hist[i].last; end
            if (hist[i].hs + 1 + D <= cyc) wa = hist[i].z;
            if (hist[i].hs + 1 <= cyc && cyc <= hist[i].hs + 1 + D) begin
                bsy = 1'b1;
                if (HAZ && (hist[i].z == cmd_a || hist[i].z == cmd_b)) rdy = 1'b0;
            end
        end
        return {rdy, rde, ra, rb, wre, wa, bsy, dn};
    endfunction

    task automatic present();
        if (pend.size() > 0 && !(drop_en && $urandom_range(0, 3) == 0)) begin
            cmd_valid = 1'b1;
            cmd_a = pend[0].a; cmd_b = pend[0].b; cmd_z = pend[0].z; cmd_last = pend[0].last;
        end else begin
            cmd_valid = 1'b0;
            cmd_a = AW'($urandom_range(0, 15));
            cmd_b = AW'($urandom_range(0, 15));
            cmd_z = AW'($urandom_range(0, 255));
            cmd_last = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic tick();
        logic [VW-1:0] e;
        cmd_t c;
        e = model_out();
        if (!rstn) begin
            hist.delete();
        end else if (cmd_valid && e[VW-1]) begin
            c.hs = cyc; c.a = cmd_a; c.b = cmd_b; c.z = cmd_z; c.last = cmd_last;
            hist.push_back(c);
            if (pend.size() > 0) pend.delete(0);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        logic [VW-1:0] e;
        rstn = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_z = '0; cmd_last = 1'b0;
        tick();
        tick();
        repeat (2) begin
            @(negedge clk); e = model_out(); n_cmp++;
            if (obs() !== e) begin n_err++; $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs(), e); end
            tick();
        end
        rstn = 1'b1;
        @(negedge clk); n_cmp++;
        if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
        tick();
    endtask

    task automatic test_single();
        logic [VW-1:0] e;
        int t0, wr_cyc, n_done;
        pend.push_back(mk(1, 2, 5, 1'b1));
        t0 = cyc; wr_cyc = -1; n_done = 0;
        repeat (D + 4) begin
            present();
            @(negedge clk); e = model_out(); n_cmp++;
            if (obs() !== e) begin n_err++; $display("FAIL single cyc=%0d got=%h exp=%h", cyc, obs(), e); end
            if (wr_en === 1'b1) wr_cyc = cyc;
            if (done === 1'b1) n_done++;
            tick();
        end
        n_cmp++;
        if (wr_cyc != t0 + 40 || n_done != 1) begin
            n_err++; $display("FAIL single_latency got wr=%0d done=%0d exp wr=%0d done=1", wr_cyc - t0, n_done, 40);
        end
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] e;
        int t0, first_wr, n_wr, n_done;
        for (int i = 0; i < 10; i++) pend.push_back(mk(i, i, 10 + i, i == 9));
        t0 = cyc; first_wr = -1; n_wr = 0; n_done = 0;
        repeat (D + 14) begin
            present();
            @(negedge clk); e = model_out(); n_cmp++;
            if (obs() !== e) begin n_err++; $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, obs(), e); end
            if (wr_en === 1'b1) begin n_wr++; if (first_wr < 0) first_wr = cyc - t0; end
            if (done === 1'b1) n_done++;
            tick();
        end
        n_cmp++;
        if (first_wr != 40 || n_wr != 10 || n_done != 1) begin
            n_err++; $display("FAIL b2b_count got first=%0d wr=%0d done=%0d exp 40/10/1", first_wr, n_wr, n_done);
        end
    endtask

    task automatic test_dependent();
        logic [VW-1:0] e;
        int gap;
        pend.push_back(mk(1, 2, 7, 1'b0));
        pend.push_back(mk(7, 3, 8, 1'b1));
        repeat (2 * D + 8) begin
            present();
            @(negedge clk); e = model_out(); n_cmp++;
            if (obs() !== e) begin n_err++; $display("FAIL dependent cyc=%0d got=%h exp=%h", cyc, obs(), e); end
            tick();
        end
        gap = (hist.size() >= 2) ? hist[hist.size()-1].hs - hist[hist.size()-2].hs : -1;
        n_cmp++;
        if (gap != (HAZ ? D + 2 : 1)) begin
            n_err++; $display("FAIL dependent_gap got=%0d exp=%0d", gap, HAZ ? D + 2 : 1);
        end
    endtask

    task automatic test_b_hazard();
        logic [VW-1:0] e;
        int gap, t0;
        pend.push_back(mk(50, 51, 20, 1'b0));
        pend.push_back(mk(21, 20, 22, 1'b0));
        repeat (2 * D + 8) begin
            present();
            @(negedge clk); e = model_out(); n_cmp++;
            if (obs() !== e) begin n_err++; $display("FAIL b_hazard cyc=%0d got=%h exp=%h", cyc, obs(), e); end
            tick();
        end
        gap = (hist.size() >= 2) ? hist[hist.size()-1].hs - hist[hist.size()-2].hs : -1;
        n_cmp++;
        if (gap != (HAZ ? D + 2 : 1)) begin
            n_err++; $display("FAIL b_hazard_gap got=%0d exp=%0d", gap, HAZ ? D + 2 : 1);
        end
        pend.push_back(mk(30, 30, 30, 1'b1));
        t0 = cyc;
        repeat (D + 4) begin
            present();
            @(negedge clk); e = model_out(); n_cmp++;
            if (obs() !== e) begin n_err++; $display("FAIL self_ref cyc=%0d got=%h exp=%h", cyc, obs(), e); end
            tick();
        end
        n_cmp++;
        if (hist.size() == 0 || hist[hist.size()-1].hs != t0) begin
            n_err++; $display("FAIL self_ref_stall got_hs=%0d exp_hs=%0d", (hist.size() > 0) ? hist[hist.size()-1].hs : -1, t0);
        end
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] e;
        int post;
        pend.push_back(mk(1, 2, 40, 1'b0));
        pend.push_back(mk(3, 4, 41, 1'b0));
        pend.push_back(mk(5, 6, 42, 1'b1));
        post = 0;
        for (int k = 0; k < D + 10; k++) begin
            rstn = (k == 20) ? 1'b0 : 1'b1;
            present();
            @(negedge clk); e = model_out(); n_cmp++;
            if (obs() !== e) begin n_err++; $display("FAIL reset_mid cyc=%0d got=%h exp=%h", cyc, obs(), e); end
            if (k > 20 && (wr_en === 1'b1 || done === 1'b1 || busy === 1'b1)) post++;
            tick();
        end
        rstn = 1'b1;
        n_cmp++;
        if (post != 0) begin n_err++; $display("FAIL reset_mid_post got=%0d exp=0", post); end
    endtask

    task automatic test_random();
        logic [VW-1:0] e;
        drop_en = 1'b1;
        repeat (400) begin
            if (pend.size() < 2 && $urandom_range(0, 1) == 1) begin
                pend.push_back(mk($urandom_range(0, 15), $urandom_range(0, 15),
                                  $urandom_range(0, 15), $urandom_range(0, 7) == 0));
            end
            present();
            @(negedge clk); e = model_out(); n_cmp++;
            if (obs() !== e) begin n_err++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs(), e); end
            tick();
        end
        drop_en = 1'b0;
        repeat (2 * D + 8) begin
            present();
            @(negedge clk); e = model_out(); n_cmp++;
            if (obs() !== e) begin n_err++; $display("FAIL drain cyc=%0d got=%h exp=%h", cyc, obs(), e); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_dependent();
        test_b_hazard();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/qpmm_issue_sched.md
# qpmm_issue_sched

In-order issue scheduler that sits directly upstream of the QPMM Montgomery multiplier and its operand/result RAMs. It accepts multiply commands (source A, source B, destination), drives the two RAM read addresses that feed the multiplier's A/B inputs, and asserts the RAM write enable and address exactly when the multiplier's Z output for that command is valid. Read-after-write hazards on in-flight destinations are resolved by stalling the command interface. The block is control-only; no operand data passes through it.

## Interface
- AW, 8, RAM address width.
- RD_LAT, 3, RAM read latency: cycles from read address to data at the multiplier inputs.
- MUL_LAT, 36, multiplier latency: cycles from A/B to Z.
- D is derived as RD_LAT+MUL_LAT (default 39); it is the total in-flight depth.

- clk  in  1  single clock; every transition occurs on its rising edge.
- rstn  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when cmd_valid && cmd_ready.
- cmd_a  in  AW  source address of operand A.
- cmd_b  in  AW  source address of operand B.
- cmd_z  in  AW  destination address.
- cmd_last  in  1  marks the final command of a batch.
- rd_en  out  1  read strobe to both RAM read ports.
- rd_addr_a  out  AW  RAM0 read address.
- rd_addr_b  out  AW  RAM1 read address.
- wr_en  out  1  write strobe for the result RAMs.
- wr_addr  out  AW  write address.
- busy  out  1  one or more commands in flight.
- done  out  1  one-cycle pulse on completion of a cmd_last command.

## Operation
- The block holds a D-entry shift register of {valid, z, last} and advances it every cycle. A command accepted in cycle t enters the register in cycle t+1.
- Issue: on a handshake in cycle t:
  - rd_en=1 in cycle t+1.
  - rd_addr_a=cmd_a and rd_addr_b=cmd_b in cycle t+1.
  - The block accepts at most one command per cycle. With no hazards, throughput is 1 command per cycle.
- Write-back:
  - The entry reaches the end of the shift register in cycle t+1+D.
  - In that cycle, wr_en=1 and wr_addr=z.
  - If last=1, done=1 in the same cycle.
- Hazard check:
  - cmd_ready=0 while cmd_a or cmd_b equals the z of any valid entry, including the entry in its wr_en cycle.
  - Otherwise cmd_ready=1.
  - cmd_ready is combinational from the current cmd_a/cmd_b and the registered entries.
  - A command already in its handshake cycle is not checked against itself.
- Destination collisions (WAW) need no check: issue is in order and latency is fixed.
- cmd_a==cmd_b is legal.
- cmd_z equal to its own cmd_a or cmd_b is legal: the read precedes the write.
- busy = OR of all entry valids.
- When rd_en=0, rd_addr_a and rd_addr_b hold their last value.
- When wr_en=0, wr_addr holds its last value.

## Timing
- Reset values (rstn=0 sampled at an edge): all entries invalid, rd_en=0, wr_en=0, done=0, busy=0, rd_addr_a=rd_addr_b=wr_addr=0. cmd_ready=0 while rstn=0.
- Reset mid-operation discards every in-flight entry. No wr_en or done occurs after reset for commands accepted before it.
- First handshake possible: the first cycle with rstn=1.
- Latency: handshake cycle t → rd_en in t+1 → wr_en in t+1+D (default t+40).
- Minimum spacing for a dependent command: handshake t → dependent handshake no earlier than t+2+D. Its read occurs the cycle after the write edge, so it returns new data.
- cmd_valid may drop while stalled; inputs are sampled only in the handshake cycle.

## Configuration
- QPMM_HAZARD_CHECK_EN defined: RAW stall logic is present, as described above.
- QPMM_HAZARD_CHECK_EN undefined:
  - cmd_ready = rstn (always 1 out of reset).
  - No comparators are built.
  - Software guarantees dependent-command spacing of at least D+2 cycles.
  - All other behaviour is identical.

## Test plan
- Single op, defaults. a=1, b=2, z=5, last=1, handshake in cycle 0 → rd_en in cycle 1 with addresses 1/2; wr_en, wr_addr=5 and done in cycle 40; busy high from cycle 1 to cycle 40.
- Ten back-to-back independent ops. z=10..19, sources 0..9, handshakes in cycles 0–9 → cmd_ready held 1; wr_en in cycles 40–49 with wr_addr 10..19; one done, on the last.
- Dependent op. op0 z=7 at cycle 0, op1 a=7 presented from cycle 1 → cmd_ready=0 in cycles 1–40; handshake in cycle 41; rd_en in 42; wr_en in 81.
- Hazard on operand B only, and a=b=z in one command → stall on b match; self-referencing command is not stalled.
- Reset mid-flight. Issue 3 ops, pull rstn low in cycle 20 for one cycle → no wr_en or done afterwards; busy=0; cmd_ready=1 in cycle 21.
- Macro undefined. Repeat the dependent-op test → handshake in cycle 1, no stall; wr_en in cycles 40 and 41.
